capture_sequencer: RTL
======================

// Module: capture_sequencer
// PURPOSE
//   Sequences the mic-sample -> RAM buffer -> consumer datapath in bursts. Discards
//   mic start-up samples, gates CAPTURE_LEN sampler words into the RAM write port,
//   then drains the RAM. The RAM read port is shared round-robin between two
//   consumers (c0 = VU meter, c1 = debug dump). Sits between i2s_capture_24, ram_logic and consumers.
// PARAMETERS
//   WIDTH        32   sample / RAM word width
//   CAPTURE_LEN  256  sample slots per burst (1..RAM DEPTH)
//   SKIP_SAMPLES 4    sampler words discarded after start, before capture (0 = none)
// PORTS
//   clk_i              in   1      single system clock
//   rst_i              in   1      asynchronous, active-high reset
//   start_i            in   1      1-cycle pulse: begin a burst (ignored unless IDLE)
//   continuous_i       in   1      1: re-enter CAPTURE after DRAIN, skipping ARM
//   sample_valid_i     in   1      1-cycle pulse: new sampler word on sample_data_i
//   sample_data_i      in   WIDTH  sampler word
//   ram_write_valid_o  out  1      write strobe to RAM
//   ram_write_data_o   out  WIDTH  write data to RAM
//   ram_write_ready_i  in   1      RAM can accept a write
//   ram_read_valid_i   in   1      RAM has a word on ram_read_data_i
//   ram_read_data_i    in   WIDTH  RAM read data
//   ram_read_ready_o   out  1      pop RAM word (transfer = valid & ready)
//   c0_ready_i         in   1      consumer 0 wants a word
//   c1_ready_i         in   1      consumer 1 wants a word
//   c0_valid_o         out  1      word for consumer 0 on cons_data_o
//   c1_valid_o         out  1      word for consumer 1 on cons_data_o
//   cons_data_o        out  WIDTH  = ram_read_data_i (combinational pass-through)
//   state_o            out  2      0 IDLE, 1 ARM, 2 CAPTURE, 3 DRAIN
//   done_o             out  1      1-cycle pulse on DRAIN exit
//   drop_count_o       out  8      saturating count of samples dropped (RAM not ready)
// BEHAVIOUR
//   Reset: state IDLE; all *_valid_o, ram_read_ready_o, done_o = 0. drop_count_o = 0.
//   ram_write_data_o = 0. Arbiter last-grant = c1, so c0 wins first. All counters = 0.
//   IDLE: no writes, no reads. start_i -> ARM (SKIP_SAMPLES>0) or CAPTURE.
//     drop_count_o clears on start.
//   ARM: each sample_valid_i is discarded and counted. On the SKIP_SAMPLES-th -> CAPTURE.
//   CAPTURE: each sample_valid_i is one slot.
//     - ram_write_ready_i=1 in the same cycle: next cycle ram_write_valid_o=1 for
//       exactly 1 cycle with that data (latency 1); words_written++.
//     - Else: drop, drop_count_o++ (saturates at 255).
//     - After CAPTURE_LEN slots (written+dropped): -> DRAIN on the cycle after the
//       last slot's write strobe. Reads are never enabled in CAPTURE.
//   DRAIN: grant to one ready consumer per cycle, combinationally.
//     - Both ready: grant the one not granted last. One ready: grant it.
//     - Grant g: ram_read_ready_o = cg_ready_i; cg_valid_o = ram_read_valid_i.
//       Other valid = 0.
//     - On transfer (ram_read_valid_i & ram_read_ready_o): last-grant <= g, words_read++.
//     - When words_read == words_written (includes 0 written): done_o pulse, then
//       continuous_i ? CAPTURE (counters cleared) : IDLE.
//     - sample_valid_i in DRAIN/IDLE is ignored; not counted as dropped.
//   Outside DRAIN: c0/c1_valid_o = 0, ram_read_ready_o = 0 regardless of consumers.
//   Simultaneous: start_i coincident with sample_valid_i in IDLE -> that sample ignored.
//     Last CAPTURE slot plus consumer ready -> no read until DRAIN is entered.
//   Counters are $clog2(CAPTURE_LEN+1) bits wide; no wrap is possible within a burst.
//   Reset mid-burst: immediate return to IDLE, in-flight write strobe suppressed.
//     The RAM shares rst_i and is flushed by its own reset.
// TESTING
//   1 Reset mid-CAPTURE (after 10 writes): outputs 0 same cycle, state_o=0,
//     no further writes after rst_i release without start_i.
//   2 CAPTURE_LEN=8, SKIP=4, RAM ready, start then 12 samples 1..12 -> writes 5..12 one
//     cycle after each valid, state_o 1->2->3, drop_count_o=0.
//   3 Same, ram_write_ready_i low on samples 7,8 -> 6 writes, drop_count_o=2, DRAIN
//     pops exactly 6, done_o pulses once.
//   4 DRAIN with c0,c1 both ready, RAM holds 6 words -> grants c0,c1,c0,c1,c0,c1,
//     data order preserved. Only c1 ready -> all 6 to c1.
//   5 continuous_i=1: after done_o, next sample written without ARM skip
//     (state 3->2); start_i pulsed in CAPTURE has no effect.
//   6 300 drops with RAM held not-ready (CAPTURE_LEN=300) -> drop_count_o=255,
//     DRAIN exits immediately with done_o.

Source files
------------

// File: rtl/capture_sequencer_if.sv
// Bus bundle for capture_sequencer: sampler input, RAM write/read ports,
// consumer handshakes and status. The slave modport is the sequencer side.
interface capture_sequencer_if #(
   parameter int WIDTH = 32
) ();
   logic             start_i;
   logic             continuous_i;
   logic             sample_valid_i;
   logic [WIDTH-1:0] sample_data_i;
   logic             ram_write_valid_o;
   logic [WIDTH-1:0] ram_write_data_o;
   logic             ram_write_ready_i;
   logic             ram_read_valid_i;
   logic [WIDTH-1:0] ram_read_data_i;
   logic             ram_read_ready_o;
   logic             c0_ready_i;
   logic             c1_ready_i;
   logic             c0_valid_o;
   logic             c1_valid_o;
   logic [WIDTH-1:0] cons_data_o;
   logic [1:0]       state_o;
   logic             done_o;
   logic [7:0]       drop_count_o;

   modport slave (
      input  start_i, continuous_i, sample_valid_i, sample_data_i,
      input  ram_write_ready_i, ram_read_valid_i, ram_read_data_i,
      input  c0_ready_i, c1_ready_i,
      output ram_write_valid_o, ram_write_data_o, ram_read_ready_o,
      output c0_valid_o, c1_valid_o, cons_data_o,
      output state_o, done_o, drop_count_o
   );

   modport master (
      output start_i, continuous_i, sample_valid_i, sample_data_i,
      output ram_write_ready_i, ram_read_valid_i, ram_read_data_i,
      output c0_ready_i, c1_ready_i,
      input  ram_write_valid_o, ram_write_data_o, ram_read_ready_o,
      input  c0_valid_o, c1_valid_o, cons_data_o,
      input  state_o, done_o, drop_count_o
   );
endinterface

// File: rtl/capture_sequencer.sv
// Burst sequencer: discards mic start-up words, gates a fixed number of sampler
// slots into the RAM write port, then drains the RAM to two round-robin consumers.
module capture_sequencer #(
   parameter int WIDTH        = 32,
   parameter int CAPTURE_LEN  = 256,
   parameter int SKIP_SAMPLES = 4
) (
   input  logic                clk_i,
   input  logic                rst_i,
   capture_sequencer_if.slave  bus
);
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ARM     = 2'd1;
   localparam logic [1:0] ST_CAPTURE = 2'd2;
   localparam logic [1:0] ST_DRAIN   = 2'd3;

   localparam int CW = $clog2(CAPTURE_LEN + 1);
   localparam int SW = (SKIP_SAMPLES > 0) ? $clog2(SKIP_SAMPLES + 1) : 1;
   localparam logic [CW-1:0] LAST_SLOT   = CW'(CAPTURE_LEN - 1);
   localparam logic [SW-1:0] LAST_SKIP   = SW'((SKIP_SAMPLES > 0) ? SKIP_SAMPLES - 1 : 0);
   localparam logic [1:0]    AFTER_START = (SKIP_SAMPLES > 0) ? ST_ARM : ST_CAPTURE;

   logic [1:0]       state_q, state_d;
   logic [SW-1:0]    skip_q, skip_d;
   logic [CW-1:0]    slot_q, slot_d;
   logic [CW-1:0]    wr_cnt_q, wr_cnt_d;
   logic [CW-1:0]    rd_cnt_q, rd_cnt_d;
   logic             fill_q, fill_d;
   logic             last_q, last_d;
   logic             wv_q, wv_d;
   logic [WIDTH-1:0] wd_q, wd_d;
   logic             done_q, done_d;
   logic [7:0]       drop_q, drop_d;
   logic             gnt_c0_s, gnt_c1_s, xfer_s;

   // Round-robin read grant; last_q = 1 means c1 was served last.
   always_comb begin
      gnt_c0_s = 1'b0;
      gnt_c1_s = 1'b0;
      if (state_q == ST_DRAIN) begin
         if (bus.c0_ready_i && bus.c1_ready_i) begin
            gnt_c0_s = last_q;
            gnt_c1_s = ~last_q;
         end else begin
            gnt_c0_s = bus.c0_ready_i;
            gnt_c1_s = bus.c1_ready_i;
         end
      end else begin
         gnt_c0_s = 1'b0;
         gnt_c1_s = 1'b0;
      end
   end

   assign xfer_s = bus.ram_read_valid_i & (gnt_c0_s | gnt_c1_s);

   // Burst sequencing and counters.
   always_comb begin
      state_d  = state_q;
      skip_d   = skip_q;
      slot_d   = slot_q;
      wr_cnt_d = wr_cnt_q;
      rd_cnt_d = rd_cnt_q;
      fill_d   = fill_q;
      last_d   = last_q;
      wv_d     = 1'b0;
      wd_d     = wd_q;
      done_d   = 1'b0;
      drop_d   = drop_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.start_i) begin
               state_d  = AFTER_START;
               skip_d   = {SW{1'b0}};
               slot_d   = {CW{1'b0}};
               wr_cnt_d = {CW{1'b0}};
               rd_cnt_d = {CW{1'b0}};
               fill_d   = 1'b0;
               drop_d   = 8'd0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ARM: begin
            if (bus.sample_valid_i) begin
               if (skip_q == LAST_SKIP) begin
                  state_d = ST_CAPTURE;
                  skip_d  = {SW{1'b0}};
               end else begin
                  skip_d = skip_q + SW'(1);
               end
            end else begin
               skip_d = skip_q;
            end
         end
         ST_CAPTURE: begin
            // fill_q holds CAPTURE for the last slot's strobe cycle.
            if (fill_q) begin
               state_d = ST_DRAIN;
               fill_d  = 1'b0;
            end else if (bus.sample_valid_i) begin
               slot_d = slot_q + CW'(1);
               fill_d = (slot_q == LAST_SLOT);
               if (bus.ram_write_ready_i) begin
                  wv_d     = 1'b1;
                  wd_d     = bus.sample_data_i;
                  wr_cnt_d = wr_cnt_q + CW'(1);
               end else if (drop_q != 8'hFF) begin
                  drop_d = drop_q + 8'd1;
               end else begin
                  drop_d = drop_q;
               end
            end else begin
               slot_d = slot_q;
            end
         end
         ST_DRAIN: begin
            if (rd_cnt_q == wr_cnt_q) begin
               done_d   = 1'b1;
               state_d  = bus.continuous_i ? ST_CAPTURE : ST_IDLE;
               slot_d   = {CW{1'b0}};
               wr_cnt_d = {CW{1'b0}};
               rd_cnt_d = {CW{1'b0}};
            end else if (xfer_s) begin
               last_d   = gnt_c1_s;
               rd_cnt_d = rd_cnt_q + CW'(1);
            end else begin
               rd_cnt_d = rd_cnt_q;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers; reset also kills any in-flight write strobe.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         skip_q   <= {SW{1'b0}};
         slot_q   <= {CW{1'b0}};
         wr_cnt_q <= {CW{1'b0}};
         rd_cnt_q <= {CW{1'b0}};
         fill_q   <= 1'b0;
         last_q   <= 1'b1;
         wv_q     <= 1'b0;
         wd_q     <= {WIDTH{1'b0}};
         done_q   <= 1'b0;
         drop_q   <= 8'd0;
      end else begin
         state_q  <= state_d;
         skip_q   <= skip_d;
         slot_q   <= slot_d;
         wr_cnt_q <= wr_cnt_d;
         rd_cnt_q <= rd_cnt_d;
         fill_q   <= fill_d;
         last_q   <= last_d;
         wv_q     <= wv_d;
         wd_q     <= wd_d;
         done_q   <= done_d;
         drop_q   <= drop_d;
      end
   end

   assign bus.ram_write_valid_o = wv_q;
   assign bus.ram_write_data_o  = wd_q;
   assign bus.ram_read_ready_o  = gnt_c0_s | gnt_c1_s;
   assign bus.c0_valid_o        = gnt_c0_s & bus.ram_read_valid_i;
   assign bus.c1_valid_o        = gnt_c1_s & bus.ram_read_valid_i;
   assign bus.cons_data_o       = bus.ram_read_data_i;
   assign bus.state_o           = state_q;
   assign bus.done_o            = done_q;
   assign bus.drop_count_o      = drop_q;
endmodule
